// File: rtl/cnt_updown_pkg.sv
// cnt_updown_pkg: shared encodings and width helper for the up/down counter
package cnt_updown_pkg;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DOWN = 1'b0;
  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT = 1;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/cnt_updown_if.sv
// cnt_updown_if: control and status bundle between a counter and its user
interface cnt_updown_if #(parameter int LEN = 8);
  logic en;
  logic up;
  logic load;
  logic [LEN-1:0] d;
  logic [LEN-1:0] q;
  logic tc;
  logic ovf;
  modport master (output en, up, load, d, input q, tc, ovf);
  modport slave (input en, up, load, d, output q, tc, ovf);
endinterface

// File: rtl/cnt_presc.sv
// cnt_presc: enable prescaler, one tick per PRESC enabled cycles
module cnt_presc
  import cnt_updown_pkg::*;
#(
  parameter int PRESC = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);
  generate
    if (PRESC == 1) begin : g_pass
      logic unused;
      assign unused = ^{clk, rst, clr};
      assign tick = en;
    end else begin : g_div
      localparam int W = clog2(PRESC);
      logic [W-1:0] pcnt;
      assign tick = en && (pcnt == W'(PRESC - 1));
      always_ff @(posedge clk)
        if (rst || clr) pcnt <= '0;
        else if (en) pcnt <= tick ? '0 : pcnt + 1'b1;
    end
  endgenerate
endmodule

// File: rtl/cnt_updown.sv
// cnt_updown: up/down modulo counter with load, wrap/saturate and cascade flags
module cnt_updown
  import cnt_updown_pkg::*;
#(
  parameter int LEN = 8,
  parameter int MOD = 2 ** LEN,
  parameter int PRESC = 1,
  parameter int SAT = MODE_WRAP
) (
  input logic clk,
  input logic rst,
  cnt_updown_if.slave bus
);
  localparam logic [LEN-1:0] MAXV = LEN'(MOD - 1);
  logic step;
  logic at_lim;
  logic ovf;
  logic [LEN-1:0] q;
  cnt_presc #(.PRESC(PRESC)) u_presc (
    .clk(clk),
    .rst(rst),
    .clr(bus.load),
    .en(bus.en),
    .tick(step)
  );
  assign at_lim = (bus.up == DIR_UP) ? (q == MAXV) : (q == '0);
  assign bus.tc = step & at_lim;
  assign bus.q = q;
  assign bus.ovf = ovf;
  always_ff @(posedge clk)
    if (rst) begin
      q <= '0;
      ovf <= 1'b0;
    end else if (bus.load) begin
      q <= (bus.d > MAXV) ? MAXV : bus.d;
      ovf <= 1'b0;
    end else if (step) begin
      q <= at_lim ? ((SAT == MODE_SAT) ? q : ((bus.up == DIR_UP) ? '0 : MAXV))
                  : ((bus.up == DIR_UP) ? q + 1'b1 : q - 1'b1);
      ovf <= at_lim;
    end else begin
      ovf <= 1'b0;
    end
endmodule

// File: tb/tb_cnt_updown.sv
// tb_cnt_updown: directed scoreboard bench for wrap, saturate, load, prescale and cascade
module tb_cnt_updown;
  import cnt_updown_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  cnt_updown_if #(.LEN(3)) a_if ();
  cnt_updown_if #(.LEN(3)) b_if ();
  cnt_updown_if #(.LEN(3)) p_if ();
  cnt_updown_if #(.LEN(4)) c0_if ();
  cnt_updown_if #(.LEN(4)) c1_if ();
  cnt_updown #(.LEN(3), .MOD(6), .PRESC(1), .SAT(MODE_WRAP)) u_a (.clk(clk), .rst(rst), .bus(a_if));
  cnt_updown #(.LEN(3), .MOD(6), .PRESC(1), .SAT(MODE_SAT)) u_b (.clk(clk), .rst(rst), .bus(b_if));
  cnt_updown #(.LEN(3), .MOD(6), .PRESC(3), .SAT(MODE_WRAP)) u_p (.clk(clk), .rst(rst), .bus(p_if));
  cnt_updown #(.LEN(4), .MOD(10), .PRESC(1), .SAT(MODE_WRAP)) u_c0 (.clk(clk), .rst(rst), .bus(c0_if));
  cnt_updown #(.LEN(4), .MOD(10), .PRESC(1), .SAT(MODE_WRAP)) u_c1 (.clk(clk), .rst(rst), .bus(c1_if));
  assign c1_if.en = c0_if.tc;
  typedef struct {
    string tag;
    logic [7:0] val;
  } exp_t;
  exp_t sb[$];
  int passed = 0;
  int total = 0;
  int fails = 0;
  int q_pat[12] = '{0, 0, 1, 1, 1, 2, 2, 2, 2, 2, 3, 3};
  bit en_pat[12] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 1, 1, 1};
  task automatic push_exp(input string tag, input logic [7:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask
  task automatic chk(input logic [7:0] obs);
    exp_t e;
    e = sb.pop_front();
    total++;
    assert (obs === e.val) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
    end
  endtask
  task automatic edge_wait;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
  initial begin
    {a_if.en, a_if.up, a_if.load} = '0;
    {b_if.en, b_if.up, b_if.load} = '0;
    {p_if.en, p_if.up, p_if.load} = '0;
    {c0_if.en, c0_if.up, c0_if.load} = '0;
    {c1_if.up, c1_if.load} = 2'b10;
    a_if.d = '0;
    b_if.d = '0;
    p_if.d = '0;
    c0_if.d = '0;
    c1_if.d = '0;
    repeat (2) edge_wait;
    rst = 1'b0;
    #1;
    push_exp("rst_q", 8'd0);
    chk(a_if.q);
    push_exp("rst_ovf", 8'd0);
    chk(a_if.ovf);
    push_exp("rst_tc", 8'd0);
    chk(a_if.tc);
    a_if.up = 1'b1;
    a_if.en = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      push_exp("wrap_q", 8'(i % 6));
      push_exp("wrap_tc", (i % 6) == 5);
      push_exp("wrap_ovf", i == 6);
      chk(a_if.q);
      chk(a_if.tc);
      chk(a_if.ovf);
      edge_wait;
    end
    a_if.load = 1'b1;
    a_if.d = 3'd3;
    edge_wait;
    a_if.load = 1'b0;
    push_exp("flip_load", 8'd3);
    chk(a_if.q);
    for (int i = 0; i < 4; i++) begin
      a_if.up = (i % 2) == 0;
      edge_wait;
      push_exp("flip_q", ((i % 2) == 0) ? 8'd4 : 8'd3);
      chk(a_if.q);
    end
    a_if.load = 1'b1;
    a_if.d = 3'd7;
    a_if.up = 1'b1;
    edge_wait;
    push_exp("clamp_q", 8'd5);
    chk(a_if.q);
    push_exp("clamp_ovf", 8'd0);
    chk(a_if.ovf);
    rst = 1'b1;
    a_if.d = 3'd2;
    edge_wait;
    rst = 1'b0;
    a_if.load = 1'b0;
    a_if.en = 1'b0;
    push_exp("rst_over_load_q", 8'd0);
    chk(a_if.q);
    b_if.load = 1'b1;
    b_if.d = 3'd1;
    edge_wait;
    b_if.load = 1'b0;
    b_if.up = DIR_DOWN;
    b_if.en = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      push_exp("sat_q", (i == 0) ? 8'd1 : 8'd0);
      push_exp("sat_tc", i > 0);
      push_exp("sat_ovf", i > 1);
      chk(b_if.q);
      chk(b_if.tc);
      chk(b_if.ovf);
      edge_wait;
    end
    b_if.en = 1'b0;
    p_if.up = 1'b1;
    for (int i = 0; i < 12; i++) begin
      p_if.en = en_pat[i];
      edge_wait;
      push_exp("presc_q", 8'(q_pat[i]));
      chk(p_if.q);
    end
    rst = 1'b1;
    p_if.en = 1'b1;
    edge_wait;
    rst = 1'b0;
    push_exp("presc_rst_q", 8'd0);
    chk(p_if.q);
    for (int i = 0; i < 3; i++) begin
      edge_wait;
      push_exp("presc_after_rst_q", (i == 2) ? 8'd1 : 8'd0);
      chk(p_if.q);
    end
    p_if.en = 1'b0;
    c0_if.up = 1'b1;
    c0_if.en = 1'b1;
    for (int i = 0; i < 25; i++) begin
      edge_wait;
      if (i == 8) begin
        push_exp("casc_tc", 8'd1);
        chk(c0_if.tc);
      end
      if (i == 9) begin
        push_exp("casc_mid_c0", 8'd0);
        chk(c0_if.q);
        push_exp("casc_mid_c1", 8'd1);
        chk(c1_if.q);
      end
    end
    push_exp("casc_c0", 8'd5);
    chk(c0_if.q);
    push_exp("casc_c1", 8'd2);
    chk(c1_if.q);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
